instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instruction_encoder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs request fields into 32-bit instruction words,
// buffers them in a 4-entry FIFO and streams them into instruction memory
// as a load session, closed by a single all-zero terminator word.
module instruction_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic [7:0]  load_base,
  input  logic        load_end,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_nop,
  input  logic [3:0]  condition_code,
  input  logic [1:0]  operation_type,
  input  logic        immediate_flag,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] operand2,
  input  logic [23:0] branch_offset,
  output logic        mem_write_enable,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_write_data,
  input  logic        mem_ready,
  output logic        busy,
  output logic        load_done,
  output logic [8:0]  word_count,
  output logic        illegal_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_TERM,
    S_DONE
  } state_t;

  localparam int unsigned FIFO_DEPTH = 4;

  state_t      state_q, state_d;
  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [31:0] fifo_d [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  wc_q, wc_d;
  logic        illegal_q, illegal_d;

  logic [31:0] enc_word;
  logic        fifo_empty;
  logic        fifo_full;
  logic        accept;
  logic        pop;
  logic        term_write;
  logic        write_fire;

  // Combinational encoding of the request fields into an instruction word
  always_comb begin
    enc_word = '0;
    if (!req_nop) begin
      case (operation_type)
        2'b00:   enc_word = {condition_code, 2'b00, immediate_flag, opcode, s_bit,
                             rn, rd, operand2};
        2'b01:   enc_word = {condition_code, 2'b01, immediate_flag, 1'b1, 1'b1,
                             s_bit, 1'b0, s_bit, rn, rd, operand2};
        2'b10:   enc_word = {condition_code, 3'b101, s_bit, branch_offset};
        default: enc_word = '0;
      endcase
    end
  end

  // Handshake and write-port decode from the registered FIFO/state
  always_comb begin
    fifo_empty       = (count_q == 3'd0);
    fifo_full        = (count_q == 3'(FIFO_DEPTH));
    req_ready        = (state_q == S_LOAD) && !fifo_full;
    accept           = req_valid && req_ready;
    term_write       = (state_q == S_TERM);
    mem_write_enable = !fifo_empty || term_write;
    mem_write_data   = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    mem_address      = addr_q;
    pop              = !fifo_empty && mem_ready;
    write_fire       = mem_write_enable && mem_ready;
    busy             = (state_q != S_IDLE);
    load_done        = (state_q == S_DONE);
    word_count       = wc_q;
    illegal_flag     = illegal_q;
  end

  // Next-state, FIFO bookkeeping and session counters
  always_comb begin
    state_d   = state_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wc_d      = wc_q;
    illegal_d = illegal_q;

    if (write_fire) begin
      addr_d = addr_q + 8'd1;
      if (wc_q != '1) begin
        wc_d = wc_q + 9'd1;
      end
    end

    if (accept) begin
      fifo_d[wr_ptr_q] = enc_word;
      wr_ptr_d         = wr_ptr_q + 2'd1;
      if (!req_nop && (operation_type == 2'b11)) begin
        illegal_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    // Push and pop in the same cycle leave occupancy unchanged
    case ({accept, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d   = S_LOAD;
          addr_d    = load_base;
          wc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_end) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fifo_empty) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wc_q      <= wc_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: fixed vectors, corner-case
// sequences and randomized sessions against a queue-based reference model.
module tb_instruction_encoder;

  logic        clk;
  logic        reset_n;
  logic        load_start;
  logic [7:0]  load_base;
  logic        load_end;
  logic        req_valid;
  logic        req_ready;
  logic        req_nop;
  logic [3:0]  condition_code;
  logic [1:0]  operation_type;
  logic        immediate_flag;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [11:0] operand2;
  logic [23:0] branch_offset;
  logic        mem_write_enable;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic        busy;
  logic        load_done;
  logic [8:0]  word_count;
  logic        illegal_flag;

  instruction_encoder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_start       (load_start),
    .load_base        (load_base),
    .load_end         (load_end),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_nop          (req_nop),
    .condition_code   (condition_code),
    .operation_type   (operation_type),
    .immediate_flag   (immediate_flag),
    .opcode           (opcode),
    .s_bit            (s_bit),
    .rn               (rn),
    .rd               (rd),
    .operand2         (operand2),
    .branch_offset    (branch_offset),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_ready        (mem_ready),
    .busy             (busy),
    .load_done        (load_done),
    .word_count       (word_count),
    .illegal_flag     (illegal_flag)
  );

  typedef struct {
    logic        nop;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        i;
    logic [3:0]  opc;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] op2;
    logic [23:0] boff;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  logic [7:0]  m_addr;
  int unsigned m_total;
  logic        m_ill;
  bit          rand_ready = 0;

  logic        prev_hold = 0;
  logic [7:0]  prev_a;
  logic [31:0] prev_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from the field layout with plain shifts
  function automatic logic [31:0] model_enc(input vec_t v);
    logic [31:0] w;
    if (v.nop || v.op == 2'b11) return 32'h0;
    w = 32'(v.cond) << 28;
    if (v.op == 2'b00)
      w = w | (32'(v.i) << 25) | (32'(v.opc) << 21) | (32'(v.s) << 20)
            | (32'(v.rn) << 16) | (32'(v.rd) << 12) | 32'(v.op2);
    else if (v.op == 2'b01)
      w = w | (32'd1 << 26) | (32'(v.i) << 25) | (32'd3 << 23) | (32'(v.s) << 22)
            | (32'(v.s) << 20) | (32'(v.rn) << 16) | (32'(v.rd) << 12) | 32'(v.op2);
    else
      w = w | (32'd5 << 25) | (32'(v.s) << 24) | 32'(v.boff);
    return w;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.nop  = ($urandom_range(0, 7) == 0);
    v.cond = 4'($urandom);
    v.op   = 2'($urandom);
    v.i    = 1'($urandom);
    v.opc  = 4'($urandom);
    v.s    = 1'($urandom);
    v.rn   = 4'($urandom);
    v.rd   = 4'($urandom);
    v.op2  = 12'($urandom);
    v.boff = 24'($urandom);
    v.exp  = model_enc(v);
    return v;
  endfunction

  // Write monitor: every completed write must match the model queue in order,
  // and a stalled write must be presented unchanged on the next cycle.
  always @(negedge clk) begin
    wr_t e;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_we", 32'(mem_write_enable), 32'd1);
        chk("hold_addr", 32'(mem_address), 32'(prev_a));
        chk("hold_data", mem_write_data, prev_d);
      end
      if (mem_write_enable && mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_address), 32'(e.a));
          chk("wr_data", mem_write_data, e.d);
        end
      end
      prev_hold = mem_write_enable && !mem_ready;
      prev_a    = mem_address;
      prev_d    = mem_write_data;
    end
  end

  // Random memory back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req_nop        = v.nop;
    condition_code = v.cond;
    operation_type = v.op;
    immediate_flag = v.i;
    opcode         = v.opc;
    s_bit          = v.s;
    rn             = v.rn;
    rd             = v.rd;
    operand2       = v.op2;
    branch_offset  = v.boff;
  endtask

  task automatic model_accept(input vec_t v);
    exp_q.push_back('{a: m_addr, d: v.exp});
    m_addr = m_addr + 8'd1;
    m_total++;
    if (!v.nop && v.op == 2'b11) m_ill = 1'b1;
  endtask

  task automatic send_req(input vec_t v);
    bit acc;
    acc = 0;
    drive(v);
    req_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (req_ready) begin
        acc = 1;
        cycle();
        break;
      end
      cycle();
    end
    req_valid = 1'b0;
    if (acc) model_accept(v);
    else chk("req_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic start_session(input logic [7:0] base);
    load_start = 1'b1;
    load_base  = base;
    cycle();
    load_start = 1'b0;
    m_addr  = base;
    m_total = 0;
    m_ill   = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_illegal", 32'(illegal_flag), 32'd0);
    chk("start_wc", 32'(word_count), 32'd0);
    chk("start_addr", 32'(mem_address), 32'(base));
  endtask

  task automatic end_session(input bit pulse);
    bit seen;
    int unsigned wc_exp;
    if (pulse) begin
      load_end = 1'b1;
      cycle();
      load_end = 1'b0;
    end
    exp_q.push_back('{a: m_addr, d: 32'h0});
    m_addr = m_addr + 8'd1;
    m_total++;
    wc_exp = (m_total > 511) ? 511 : m_total;
    seen = 0;
    for (int k = 0; k < 3000; k++) begin
      if (load_done) begin
        seen = 1;
        break;
      end
      cycle();
    end
    chk("load_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("done_wc", 32'(word_count), wc_exp);
      chk("done_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_illegal", 32'(illegal_flag), 32'(m_ill));
      cycle();
      chk("done_pulse_len", 32'(load_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_we", 32'(mem_write_enable), 32'd0);
    end
  endtask

  vec_t tbl[7];
  vec_t rv[5];
  vec_t v;

  initial begin
    // Expected words below are derived by hand from the field layouts.
    tbl[0] = '{nop:0, cond:4'hE, op:2'b00, i:0, opc:4'b0100, s:1, rn:4'd1, rd:4'd2,
               op2:12'h003, boff:24'h0, exp:32'hE091_2003};
    tbl[1] = '{nop:0, cond:4'hE, op:2'b01, i:1, opc:4'hF, s:1, rn:4'd3, rd:4'd4,
               op2:12'h004, boff:24'hFFFFFF, exp:32'hE7D3_4004};
    tbl[2] = '{nop:0, cond:4'hD, op:2'b10, i:1, opc:4'hA, s:1, rn:4'd7, rd:4'd9,
               op2:12'hFFF, boff:24'h00_0010, exp:32'hDB00_0010};
    tbl[3] = '{nop:1, cond:4'hF, op:2'b00, i:1, opc:4'hF, s:1, rn:4'hF, rd:4'hF,
               op2:12'hFFF, boff:24'hFFFFFF, exp:32'h0};
    tbl[4] = '{nop:0, cond:4'hC, op:2'b11, i:1, opc:4'h5, s:1, rn:4'h5, rd:4'h5,
               op2:12'h555, boff:24'h555555, exp:32'h0};
    tbl[5] = '{nop:0, cond:4'hA, op:2'b01, i:0, opc:4'h0, s:0, rn:4'd5, rd:4'd6,
               op2:12'hFFF, boff:24'h0, exp:32'hA585_6FFF};
    tbl[6] = '{nop:0, cond:4'h0, op:2'b00, i:1, opc:4'hF, s:0, rn:4'hF, rd:4'h0,
               op2:12'hABC, boff:24'h0, exp:32'h03EF_0ABC};

    reset_n = 1'b0; load_start = 0; load_base = 0; load_end = 0; req_valid = 0;
    mem_ready = 1'b1;
    drive(tbl[3]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data", mem_write_data, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_illegal", 32'(illegal_flag), 32'd0);
    reset_n = 1'b1;
    cycle();

    // load_end while idle does nothing
    load_end = 1'b1; cycle(); load_end = 1'b0;
    chk("idle_load_end_busy", 32'(busy), 32'd0);

    // Single DP word then terminator
    start_session(8'h10);
    send_req(tbl[0]);
    end_session(1);

    // Vector table in one session
    start_session(8'h10);
    for (int t = 0; t < 7; t++) send_req(tbl[t]);
    end_session(1);
    chk("illegal_sticky", 32'(illegal_flag), 32'd1);
    start_session(8'h50);
    // load_start during LOAD must not rebase the session
    load_start = 1'b1; load_base = 8'h77; cycle(); load_start = 1'b0;
    send_req(tbl[2]);
    end_session(1);

    // Back-pressure: four fill the FIFO, fifth waits
    start_session(8'h20);
    mem_ready = 1'b0;
    for (int t = 0; t < 5; t++) rv[t] = rand_vec();
    for (int t = 0; t < 4; t++) send_req(rv[t]);
    drive(rv[4]);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("full_ready_low", 32'(req_ready), 32'd0);
      chk("stall_addr", 32'(mem_address), 32'h20);
      chk("stall_data", mem_write_data, rv[0].exp);
      cycle();
    end
    mem_ready = 1'b1;
    send_req(rv[4]);
    end_session(1);

    // Address wrap past 255
    start_session(8'hFE);
    for (int t = 0; t < 3; t++) send_req(rand_vec());
    end_session(1);

    // Request accepted in the same cycle as load_end is kept
    start_session(8'h30);
    send_req(tbl[5]);
    drive(tbl[6]);
    chk("end_same_cycle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; load_end = 1'b1;
    cycle();
    req_valid = 1'b0; load_end = 1'b0;
    model_accept(tbl[6]);
    end_session(0);

    // word_count saturation
    start_session(8'h00);
    for (int t = 0; t < 515; t++) send_req(tbl[3]);
    end_session(1);

    // Randomized sessions with random back-pressure
    rand_ready = 1;
    for (int s = 0; s < 8; s++) begin
      start_session(8'($urandom));
      for (int t = 0; t < int'($urandom_range(1, 14)); t++) begin
        send_req(rand_vec());
        repeat ($urandom_range(0, 2)) cycle();
      end
      end_session(1);
    end
    rand_ready = 0;
    mem_ready = 1'b1;
    cycle();

    // Reset mid-session with three words queued
    start_session(8'h40);
    mem_ready = 1'b0;
    for (int t = 0; t < 3; t++) send_req(tbl[0]);
    chk("queued_we", 32'(mem_write_enable), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_write_enable), 32'd0);
    chk("mid_rst_addr", 32'(mem_address), 32'd0);
    chk("mid_rst_data", mem_write_data, 32'd0);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    cycle();
    cycle();
    reset_n = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    chk("post_rst_we", 32'(mem_write_enable), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
